// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and sequencer for the 64 KB byte-wide main memory.
// Shares memory between port A (CPU) and port B (loader/DMA).
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   a_req/a_rw        port A request (held until a_ack), 1 = read
//   a_addr/a_wdata    port A address and write data
//   a_ack/a_rdata     port A completion pulse, read data (held)
//   b_*               same set for port B
//   mem_en/mem_rw     memory enable, direction (1 = read)
//   mem_addr/wdata    memory address and write data
//   mem_rdata         memory read data (combinational from memory)
//   grant             one-hot {B,A} owner of current transfer
//   busy              high whenever a transfer is in flight
module mem_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_EN       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("mem_bus_arbiter: WAIT_CYCLES must be >= 1");
    end

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_b_q, last_b_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              pick_b;

    // B wins when alone, or on a tie when round-robin says it is B's turn.
    assign pick_b = (b_req && !a_req) ||
                    (a_req && b_req && (RR_EN != 0) && !last_b_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        last_b_d  = last_b_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        unique case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                if (a_req || b_req) begin
                    state_d  = ACCESS;
                    grant_d  = pick_b ? 2'b10 : 2'b01;
                    last_b_d = pick_b;
                    rw_d     = pick_b ? b_rw : a_rw;
                    addr_d   = pick_b ? b_addr : a_addr;
                    wdata_d  = pick_b ? b_wdata : a_wdata;
                    cnt_d    = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RELEASE;
                    if (rw_q) begin
                        if (grant_q[1]) begin
                            b_rdata_d = mem_rdata;
                        end else begin
                            a_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= 2'b00;
            last_b_q  <= 1'b1;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            last_b_q  <= last_b_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign mem_en    = (state_q == ACCESS);
    assign a_ack     = (state_q == RELEASE) && grant_q[0];
    assign b_ack     = (state_q == RELEASE) && grant_q[1];
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign mem_rw    = rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (W=1/RR and W=3/fixed),
// transaction-level timeline model, directed cases plus random traffic.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req [2], a_rw [2], a_ack [2];
    logic        b_req [2], b_rw [2], b_ack [2];
    logic [15:0] a_addr [2], b_addr [2], mem_addr [2];
    logic [7:0]  a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
    logic [7:0]  mem_wdata [2], mem_rdata [2];
    logic        mem_en [2], mem_rw [2], busy [2];
    logic [1:0]  grant [2];

    logic [7:0]  ram  [2][65536];
    logic [7:0]  mram [2][65536];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int          t0 [2];
    bit          own [2];
    bit          lastb [2];
    logic        trw [2];
    logic [15:0] tad [2];
    logic [7:0]  twd [2];
    logic [7:0]  trd [2];
    logic [7:0]  erd [2][2];

    always #5 clk = ~clk;

    assign mem_rdata[0] = ram[0][mem_addr[0]];
    assign mem_rdata[1] = ram[1][mem_addr[1]];

    mem_bus_arbiter #(.WAIT_CYCLES(1), .RR_EN(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req[0]), .a_rw(a_rw[0]), .a_addr(a_addr[0]),
        .a_wdata(a_wdata[0]), .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_rw(b_rw[0]), .b_addr(b_addr[0]),
        .b_wdata(b_wdata[0]), .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
        .mem_en(mem_en[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .grant(grant[0]), .busy(busy[0])
    );

    mem_bus_arbiter #(.WAIT_CYCLES(3), .RR_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req[1]), .a_rw(a_rw[1]), .a_addr(a_addr[1]),
        .a_wdata(a_wdata[1]), .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_rw(b_rw[1]), .b_addr(b_addr[1]),
        .b_wdata(b_wdata[1]), .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
        .mem_en(mem_en[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .grant(grant[1]), .busy(busy[1])
    );

    function automatic int wc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit rr(input int k);
        return (k == 0);
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h",
                     nm, k, cyc, act, exp);
        end
    endtask

    // Timeline model: an arbitration in cycle t0 owns the bus for
    // t0+1..t0+W (mem_en), acks in t0+W+1, re-arbitrates from t0+W+2.
    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int   w;
            bit   inx, acc, ackc, pb;
            logic [1:0] g;
            w = wc(k);
            if (!rst_n) begin
                t0[k] = -100;
                lastb[k] = 1'b1;
                trw[k] = 1'b1;
                tad[k] = 16'h0;
                twd[k] = 8'h0;
                erd[k][0] = 8'h0;
                erd[k][1] = 8'h0;
            end
            inx  = (cyc >= t0[k] + 1) && (cyc <= t0[k] + w + 1);
            acc  = (cyc >= t0[k] + 1) && (cyc <= t0[k] + w);
            ackc = (cyc == t0[k] + w + 1);
            if (ackc && trw[k]) erd[k][own[k]] = trd[k];
            g = inx ? (own[k] ? 2'b10 : 2'b01) : 2'b00;
            chk("mem_en", k, 32'(mem_en[k]), 32'(acc));
            chk("busy", k, 32'(busy[k]), 32'(inx));
            chk("grant", k, 32'(grant[k]), 32'(g));
            chk("mem_rw", k, 32'(mem_rw[k]), 32'(trw[k]));
            chk("mem_addr", k, 32'(mem_addr[k]), 32'(tad[k]));
            chk("mem_wdata", k, 32'(mem_wdata[k]), 32'(twd[k]));
            chk("a_ack", k, 32'(a_ack[k]), 32'(ackc && !own[k]));
            chk("b_ack", k, 32'(b_ack[k]), 32'(ackc && own[k]));
            chk("a_rdata", k, 32'(a_rdata[k]), 32'(erd[k][0]));
            chk("b_rdata", k, 32'(b_rdata[k]), 32'(erd[k][1]));
            if (mem_en[k] && !mem_rw[k]) ram[k][mem_addr[k]] = mem_wdata[k];
            if (rst_n && cyc >= t0[k] + w + 2 && (a_req[k] || b_req[k])) begin
                if (a_req[k] && b_req[k]) pb = rr(k) ? !lastb[k] : 1'b0;
                else pb = b_req[k];
                t0[k] = cyc;
                own[k] = pb;
                lastb[k] = pb;
                trw[k] = pb ? b_rw[k] : a_rw[k];
                tad[k] = pb ? b_addr[k] : a_addr[k];
                twd[k] = pb ? b_wdata[k] : a_wdata[k];
                if (trw[k]) trd[k] = mram[k][tad[k]];
                else mram[k][tad[k]] = twd[k];
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drv(input int k, input bit p, input logic rq,
                       input logic rw, input logic [15:0] ad,
                       input logic [7:0] wd);
        if (p) begin
            b_req[k] = rq; b_rw[k] = rw; b_addr[k] = ad; b_wdata[k] = wd;
        end else begin
            a_req[k] = rq; a_rw[k] = rw; a_addr[k] = ad; a_wdata[k] = wd;
        end
    endtask

    task automatic xfer(input int k, input bit p, input logic rw,
                        input logic [15:0] ad, input logic [7:0] wd,
                        output int en_n, output int ack_at,
                        output int rw_bad);
        drv(k, p, 1'b1, rw, ad, wd);
        en_n = 0;
        ack_at = -1;
        rw_bad = 0;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            at_neg();
            if (mem_en[k]) begin
                en_n++;
                if (mem_rw[k] !== rw || mem_addr[k] !== ad) rw_bad++;
            end
            if ((p ? b_ack[k] : a_ack[k]) == 1'b1) ack_at = i;
            to_pos();
        end
        drv(k, p, 1'b0, rw, ad, wd);
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] r;
        case ($urandom_range(0, 4))
            0: r = 16'h0000;
            1: r = 16'hFFFF;
            2: r = 16'h1234;
            3: r = {12'h000, 4'($urandom)};
            default: r = {12'h5A0, 4'($urandom)};
        endcase
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_n, ack_at, rw_bad;
        int s0 [4];
        int s1 [4];
        int n0, n1, nb1;
        logic [1:0] pg [2];
        int first [2];
        bit seen [2][2];

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 65536; i++) begin
                ram[k][i]  = 8'(i * 37 + (i >> 8));
                mram[k][i] = 8'(i * 37 + (i >> 8));
            end
            ram[k][0]  = 8'hF1;
            mram[k][0] = 8'hF1;
            drv(k, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
            drv(k, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
            own[k] = 1'b0;
            trd[k] = 8'h0;
        end
        rst_n = 1'b0;

        // Reset values.
        at_neg();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_rw", k, 32'(mem_rw[k]), 32'd1);
            chk("rst_mem_en", k, 32'(mem_en[k]), 32'd0);
            chk("rst_grant", k, 32'(grant[k]), 32'd0);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
        end
        to_pos();
        rst_n = 1'b1;
        repeat (3) begin
            at_neg();
            chk("idle_busy", 0, 32'(busy[0]), 32'd0);
            to_pos();
        end

        // Single read of preloaded address 0.
        xfer(0, 1'b0, 1'b1, 16'h0000, 8'h00, en_n, ack_at, rw_bad);
        chk("rd0_en_cycles", 0, 32'(en_n), 32'd1);
        chk("rd0_ack_cycle", 0, 32'(ack_at), 32'd2);
        chk("rd0_rdata", 0, 32'(a_rdata[0]), 32'hF1);

        // B write then A read of the same address.
        xfer(0, 1'b1, 1'b0, 16'h1234, 8'h5A, en_n, ack_at, rw_bad);
        chk("wr_en_cycles", 0, 32'(en_n), 32'd1);
        chk("wr_rw_stable", 0, 32'(rw_bad), 32'd0);
        chk("wr_ack_cycle", 0, 32'(ack_at), 32'd2);
        xfer(0, 1'b0, 1'b1, 16'h1234, 8'h00, en_n, ack_at, rw_bad);
        chk("raw_a_rdata", 0, 32'(a_rdata[0]), 32'h5A);
        chk("raw_b_rdata", 0, 32'(b_rdata[0]), 32'h00);
        chk("model_a_rd", 0, 32'(erd[0][0]), 32'h5A);

        // Three wait cycles, read of top address.
        xfer(1, 1'b0, 1'b1, 16'hFFFF, 8'h00, en_n, ack_at, rw_bad);
        chk("w3_en_cycles", 1, 32'(en_n), 32'd3);
        chk("w3_ack_cycle", 1, 32'(ack_at), 32'd4);
        chk("w3_rdata", 1, 32'(a_rdata[1]), 32'hDA);

        // Contention from reset with both requests held.
        rst_n = 1'b0;
        at_neg();
        to_pos();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drv(k, 1'b0, 1'b1, 1'b1, 16'h0003, 8'h00);
            drv(k, 1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h00);
            pg[k] = 2'b00;
        end
        n0 = 0; n1 = 0; nb1 = 0;
        for (int i = 0; i < 4; i++) begin
            s0[i] = 0; s1[i] = 0;
        end
        repeat (20) begin
            at_neg();
            if (grant[0] != 2'b00 && pg[0] == 2'b00 && n0 < 4) begin
                s0[n0] = int'(grant[0]); n0++;
            end
            if (grant[1] != 2'b00 && pg[1] == 2'b00 && n1 < 4) begin
                s1[n1] = int'(grant[1]); n1++;
            end
            if (b_ack[1]) nb1++;
            pg[0] = grant[0];
            pg[1] = grant[1];
            to_pos();
        end
        chk("rr_g0", 0, 32'(s0[0]), 32'd1);
        chk("rr_g1", 0, 32'(s0[1]), 32'd2);
        chk("rr_g2", 0, 32'(s0[2]), 32'd1);
        chk("rr_g3", 0, 32'(s0[3]), 32'd2);
        chk("fp_g0", 1, 32'(s1[0]), 32'd1);
        chk("fp_g1", 1, 32'(s1[1]), 32'd1);
        chk("fp_g2", 1, 32'(s1[2]), 32'd1);
        chk("fp_b_ack_count", 1, 32'(nb1), 32'd0);
        for (int k = 0; k < 2; k++) begin
            drv(k, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
            drv(k, 1'b1, 1'b0, 1'b1, 16'h0, 8'h0);
        end
        repeat (8) begin
            at_neg();
            to_pos();
        end

        // Reset during a B write access.
        drv(1, 1'b1, 1'b1, 1'b0, 16'h4000, 8'h77);
        at_neg();
        to_pos();
        at_neg();
        chk("rstw_en_before", 1, 32'(mem_en[1]), 32'd1);
        chk("rstw_rw_before", 1, 32'(mem_rw[1]), 32'd0);
        to_pos();
        rst_n = 1'b0;
        drv(1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'h77);
        at_neg();
        chk("rstw_en_after", 1, 32'(mem_en[1]), 32'd0);
        chk("rstw_b_ack", 1, 32'(b_ack[1]), 32'd0);
        to_pos();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drv(k, 1'b0, 1'b1, 1'b1, 16'h0001, 8'h0);
            drv(k, 1'b1, 1'b1, 1'b1, 16'h0002, 8'h0);
            first[k] = 0;
        end
        repeat (6) begin
            at_neg();
            for (int k = 0; k < 2; k++)
                if (first[k] == 0 && grant[k] != 2'b00) first[k] = int'(grant[k]);
            to_pos();
        end
        chk("post_rst_first", 0, 32'(first[0]), 32'd1);
        chk("post_rst_first", 1, 32'(first[1]), 32'd1);

        // Random traffic on all four requesters.
        for (int k = 0; k < 2; k++) begin
            seen[k][0] = 1'b1;
            seen[k][1] = 1'b1;
        end
        for (int t = 0; t < 3000; t++) begin
            at_neg();
            for (int k = 0; k < 2; k++) begin
                seen[k][0] = a_ack[k];
                seen[k][1] = b_ack[k];
            end
            to_pos();
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    logic rq;
                    rq = (p == 1) ? b_req[k] : a_req[k];
                    if (!rq || seen[k][p])
                        drv(k, p[0], 1'($urandom_range(0, 2) != 0),
                            1'($urandom_range(0, 1)), pick_addr(),
                            8'($urandom));
                    else if ($urandom_range(0, 19) == 0)
                        drv(k, p[0], 1'b0,
                            (p == 1) ? b_rw[k] : a_rw[k],
                            (p == 1) ? b_addr[k] : a_addr[k],
                            (p == 1) ? b_wdata[k] : a_wdata[k]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            drv(k, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
            drv(k, 1'b1, 1'b0, 1'b1, 16'h0, 8'h0);
        end
        repeat (8) begin
            at_neg();
            to_pos();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
